// File: rtl/rr_mux.sv
// CH-input registered multiplexer with per-channel valid/ready handshake.
// Selection is either a fixed channel index or round-robin arbitration.
module rr_mux #(
   parameter int W  = 3,
   parameter int CH = 4,
   localparam int SW = $clog2(CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mode,
   input  logic [SW-1:0]   sel,
   input  logic [CH*W-1:0] in_data,
   input  logic [CH-1:0]   in_valid,
   output logic [CH-1:0]   in_ready,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_ch,
   output logic            out_valid,
   input  logic            out_ready
);

   localparam logic [SW:0]   CH_V = (SW+1)'(CH);
   localparam logic [SW-1:0] LAST = SW'(CH - 1);

   logic [W-1:0]  out_data_q, out_data_d;
   logic [SW-1:0] out_ch_q, out_ch_d;
   logic          out_valid_q, out_valid_d;
   logic [SW-1:0] ptr_q, ptr_d;

   logic          load;
   logic          grant_vld;
   logic [SW-1:0] grant_idx;
   logic [SW:0]   idx_sum;

   assign load = ~out_valid_q | out_ready;

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      idx_sum   = '0;
      if (!mode) begin
         if (int'(sel) < CH) begin
            if (in_valid[sel]) begin
               grant_vld = 1'b1;
               grant_idx = sel;
            end
         end
      end else begin
         // Search ptr, ptr+1, ... wrapping explicitly so non-power-of-two CH works.
         for (int k = 0; k < CH; k++) begin
            idx_sum = {1'b0, ptr_q} + (SW+1)'(k);
            if (idx_sum >= CH_V) idx_sum = idx_sum - CH_V;
            if (!grant_vld && in_valid[idx_sum[SW-1:0]]) begin
               grant_vld = 1'b1;
               grant_idx = idx_sum[SW-1:0];
            end
         end
      end
   end

   // Suppressed during reset so no handshake completes while state is being cleared.
   assign in_ready = (load && grant_vld && !rst) ? (CH'(1) << grant_idx) : '0;

   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_valid_d = grant_vld;
         if (grant_vld) begin
            out_data_d = in_data[int'(grant_idx)*W +: W];
            out_ch_d   = grant_idx;
            if (mode) ptr_d = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: a CH=4 and a CH=3 instance checked against a queue-free
// behavioural model of grant selection, output register and round-robin pointer.
module tb_rr_mux;
   localparam int W = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        mode4, ordy4, ov4;
   logic [1:0]  sel4, och4;
   logic [11:0] data4;
   logic [3:0]  valid4, ready4;
   logic [2:0]  od4;

   logic        mode3, ordy3, ov3;
   logic [1:0]  sel3, och3;
   logic [8:0]  data3;
   logic [2:0]  valid3, ready3;
   logic [2:0]  od3;

   rr_mux #(.W(W), .CH(4)) u_dut4 (
      .clk(clk), .rst(rst), .mode(mode4), .sel(sel4), .in_data(data4),
      .in_valid(valid4), .in_ready(ready4), .out_data(od4), .out_ch(och4),
      .out_valid(ov4), .out_ready(ordy4)
   );

   rr_mux #(.W(W), .CH(3)) u_dut3 (
      .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(data3),
      .in_valid(valid3), .in_ready(ready3), .out_data(od3), .out_ch(och3),
      .out_valid(ov3), .out_ready(ordy3)
   );

   int checks = 0;
   int errors = 0;

   // Model state: index 0 is the CH=4 instance, index 1 the CH=3 instance.
   int m_valid[2], m_data[2], m_ch[2], m_ptr[2];
   logic [3:0] exp_rdy4, smp_rdy4;
   logic [2:0] exp_rdy3, smp_rdy3;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = 0; m_data[i] = 0; m_ch[i] = 0; m_ptr[i] = 0;
      end
   endtask

   task automatic ref_grant(input int n, input int md, input int s, input int vld,
                            input int ptr, output int found, output int g);
      found = 0;
      g     = 0;
      if (md == 0) begin
         if (s < n && ((vld >> s) & 1) == 1) begin found = 1; g = s; end
      end else begin
         for (int k = 0; k < n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (found == 0 && ((vld >> c) & 1) == 1) begin found = 1; g = c; end
         end
      end
   endtask

   task automatic model_step(input int id, input int n, input int md, input int s,
                             input int vld, input int dat, input int ordy, output int rdy);
      int f, g;
      bit load;
      ref_grant(n, md, s, vld, m_ptr[id], f, g);
      load = (m_valid[id] == 0) || (ordy != 0);
      rdy  = (load && f != 0) ? (1 << g) : 0;
      if (load) begin
         m_valid[id] = f;
         if (f != 0) begin
            m_data[id] = (dat >> (g * W)) & 7;
            m_ch[id]   = g;
            if (md == 1) m_ptr[id] = (g + 1) % n;
         end
      end
   endtask

   // Sample combinational ready before the edge, advance the model, then clock.
   task automatic tick();
      int r4, r3;
      #1;
      smp_rdy4 = ready4;
      smp_rdy3 = ready3;
      model_step(0, 4, int'(mode4), int'(sel4), int'(valid4), int'(data4), int'(ordy4), r4);
      model_step(1, 3, int'(mode3), int'(sel3), int'(valid3), int'(data3), int'(ordy3), r3);
      exp_rdy4 = 4'(r4);
      exp_rdy3 = 3'(r3);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] exp4();
      return {exp_rdy4, 1'(m_valid[0]), 3'(m_data[0]), 2'(m_ch[0])};
   endfunction

   function automatic logic [8:0] exp3();
      return {exp_rdy3, 1'(m_valid[1]), 3'(m_data[1]), 2'(m_ch[1])};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if ({ready4, ov4, od4, och4} !== 10'b0) begin
         errors++; $display("FAIL reset4: got %b want 0", {ready4, ov4, od4, och4});
      end
      checks++;
      if ({ready3, ov3, od3, och3} !== 9'b0) begin
         errors++; $display("FAIL reset3: got %b want 0", {ready3, ov3, od3, och3});
      end
      checks++;
      rst = 1'b0;
      model_reset();
      tick();
      if ({smp_rdy4, ov4, od4, och4} !== 10'b0) begin
         errors++; $display("FAIL post_reset_idle: got %b want 0", {smp_rdy4, ov4, od4, och4});
      end
      checks++;
      mode4  = 1'b1;
      valid4 = 4'b0001;
      data4  = 12'h001;
      tick();
      if ({ov4, od4, och4} !== {1'b1, 3'd1, 2'd0}) begin
         errors++; $display("FAIL reset_preload: got v=%b d=%0d ch=%0d want v=1 d=1 ch=0", ov4, od4, och4);
      end
      checks++;
      ordy4 = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      if ({ready4, ov4, od4, och4} !== 10'b0) begin
         errors++; $display("FAIL reset_async: got %b want 0 before edge", {ready4, ov4, od4, och4});
      end
      checks++;
      model_reset();
      @(posedge clk);
      #1;
      rst    = 1'b0;
      valid4 = 4'b0000;
      ordy4  = 1'b1;
   endtask

   task automatic test_fixed();
      mode4  = 1'b0;
      sel4   = 2'd2;
      valid4 = 4'b1111;
      data4  = {3'd4, 3'd3, 3'd2, 3'd1};
      ordy4  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if ({smp_rdy4, ov4, od4, och4} !== exp4()) begin
            errors++; $display("FAIL fixed_model cyc %0d: got %b want %b", i, {smp_rdy4, ov4, od4, och4}, exp4());
         end
         checks++;
         if ({smp_rdy4, ov4, od4, och4} !== {4'b0100, 1'b1, 3'd3, 2'd2}) begin
            errors++; $display("FAIL fixed_const cyc %0d: got %b want 0100_1_011_10", i, {smp_rdy4, ov4, od4, och4});
         end
         checks++;
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] seq [6];
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      mode4 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if ({smp_rdy4, ov4, od4, och4} !== exp4()) begin
            errors++; $display("FAIL rr_model cyc %0d: got %b want %b", i, {smp_rdy4, ov4, od4, och4}, exp4());
         end
         checks++;
         if (och4 !== seq[i] || od4 !== 3'(seq[i] + 2'd1) || $countones(smp_rdy4) != 1) begin
            errors++; $display("FAIL rr_seq cyc %0d: got ch=%0d d=%0d rdy=%b want ch=%0d d=%0d", i, och4, od4, smp_rdy4, seq[i], seq[i] + 1);
         end
         checks++;
      end
   endtask

   task automatic test_sparse();
      valid4 = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         if ({smp_rdy4, ov4, od4, och4} !== exp4()) begin
            errors++; $display("FAIL sparse_model cyc %0d: got %b want %b", i, {smp_rdy4, ov4, od4, och4}, exp4());
         end
         checks++;
         if ((smp_rdy4 & 4'b0101) !== 4'b0000 || och4[0] !== 1'b1) begin
            errors++; $display("FAIL sparse_chan cyc %0d: got rdy=%b ch=%0d want odd channel only", i, smp_rdy4, och4);
         end
         checks++;
      end
   endtask

   task automatic test_backpressure();
      mode4  = 1'b0;
      sel4   = 2'd1;
      valid4 = 4'b1111;
      tick();
      if ({ov4, och4} !== {1'b1, 2'd1}) begin
         errors++; $display("FAIL bp_load: got v=%b ch=%0d want v=1 ch=1", ov4, och4);
      end
      checks++;
      mode4 = 1'b1;
      ordy4 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if ({smp_rdy4, ov4, od4, och4} !== {4'b0000, 1'b1, 3'd2, 2'd1}) begin
            errors++; $display("FAIL bp_hold cyc %0d: got %b want 0000_1_010_01", i, {smp_rdy4, ov4, od4, och4});
         end
         checks++;
      end
      ordy4 = 1'b1;
      tick();
      if ({smp_rdy4, ov4, od4, och4} !== {4'b0100, 1'b1, 3'd3, 2'd2} || exp4() !== {4'b0100, 1'b1, 3'd3, 2'd2}) begin
         errors++; $display("FAIL bp_release: got %b want 0100_1_011_10", {smp_rdy4, ov4, od4, och4});
      end
      checks++;
   endtask

   task automatic test_sel_no_grant();
      mode4  = 1'b0;
      sel4   = 2'd3;
      valid4 = 4'b0111;
      for (int i = 0; i < 2; i++) begin
         tick();
         if ({smp_rdy4, ov4, od4, och4} !== {4'b0000, 1'b0, 3'd3, 2'd2}) begin
            errors++; $display("FAIL sel_no_grant cyc %0d: got %b want 0000_0_011_10", i, {smp_rdy4, ov4, od4, och4});
         end
         checks++;
      end
   endtask

   task automatic test_ch3_wrap();
      logic [1:0] seq [4];
      seq    = '{2'd0, 2'd1, 2'd2, 2'd0};
      mode3  = 1'b1;
      valid3 = 3'b111;
      data3  = {3'd3, 3'd2, 3'd1};
      ordy3  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if ({smp_rdy3, ov3, od3, och3} !== exp3() || och3 !== seq[i]) begin
            errors++; $display("FAIL ch3_wrap cyc %0d: got ch=%0d full=%b want ch=%0d full=%b", i, och3, {smp_rdy3, ov3, od3, och3}, seq[i], exp3());
         end
         checks++;
      end
      mode3 = 1'b0;
      sel3  = 2'd3;
      tick();
      if ({smp_rdy3, ov3} !== 4'b0000) begin
         errors++; $display("FAIL ch3_sel_oob: got rdy=%b v=%b want 000 0", smp_rdy3, ov3);
      end
      checks++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         mode4  = 1'($urandom_range(0, 1));
         sel4   = 2'($urandom_range(0, 3));
         valid4 = 4'($urandom);
         data4  = 12'($urandom);
         ordy4  = ($urandom_range(0, 3) != 0);
         mode3  = 1'($urandom_range(0, 1));
         sel3   = 2'($urandom_range(0, 3));
         valid3 = 3'($urandom);
         data3  = 9'($urandom);
         ordy3  = ($urandom_range(0, 3) != 0);
         tick();
         if ({smp_rdy4, ov4, od4, och4} !== exp4()) begin
            errors++; $display("FAIL random4 cyc %0d: got %b want %b", i, {smp_rdy4, ov4, od4, och4}, exp4());
         end
         checks++;
         if ({smp_rdy3, ov3, od3, och3} !== exp3()) begin
            errors++; $display("FAIL random3 cyc %0d: got %b want %b", i, {smp_rdy3, ov3, od3, och3}, exp3());
         end
         checks++;
      end
   endtask

   initial begin
      rst    = 1'b1;
      mode4  = 1'b0; sel4 = '0; data4 = '0; valid4 = '0; ordy4 = 1'b1;
      mode3  = 1'b0; sel3 = '0; data3 = '0; valid3 = '0; ordy3 = 1'b1;
      model_reset();
      test_reset();
      test_fixed();
      test_round_robin();
      test_sparse();
      test_backpressure();
      test_sel_no_grant();
      test_ch3_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
